instr_dispatch_seq: RTL and testbench
=====================================

Name: instr_dispatch_seq

Overview:
- Instruction fetch/decode sequencer that acts as the initiator for the register/ALU operation sequencer.
- Fetches 16-bit instructions from program memory, handles NOP/JMP/HALT locally, and hands ALU instructions off to the ALU sequencer.
- Handoff: registered parameter1/parameter2 plus a donefetch pulse, then start is held until done returns.
- Sits between program memory and the ALU operation FSM in the microcontroller top level.

Parameters:
PC_W, 8, program counter / memory address width
TIMEOUT, 16, maximum EXEC cycles waiting for done before error
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-low reset
run  input  1  level; enables fetching from IDLE
mem_rd  output  1  program memory read strobe
mem_addr  output  PC_W  program memory address (= pc)
mem_data  input  16  instruction word, valid exactly one cycle after mem_rd
done  input  1  completion flag from ALU sequencer
donefetch  output  1  one-cycle pulse; returns ALU sequencer to its initial state
start  output  1  step/advance enable to ALU sequencer
parameter1  output  6  destination/first-operand register select
parameter2  output  6  second-operand register select
alu_sel  output  3  ALU function code (opcode[2:0])
pc  output  PC_W  current program counter
halted  output  1  sticky; HALT executed
err  output  1  sticky; illegal instruction or done timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE; pc = RESET_PC.
  - All other outputs 0; instruction register ir = 0; timeout counter = 0.
- Instruction format: opcode = ir[15:12], p1 = ir[11:6], p2 = ir[5:0].
- Opcode map: 0x0 NOP; 0x1–0x7 ALU op; 0x8 JMP (target = ir[PC_W-1:0]); 0xF HALT; 0x9–0xE illegal.
- Legal register selects are 0–4 (R0–R3, P0). An ALU op with p1>4 or p2>4 is illegal.
- States:
  - IDLE: outputs idle. run=1 -> FETCH.
  - FETCH: mem_rd=1, mem_addr=pc, one cycle -> LATCH.
  - LATCH: ir <= mem_data -> DECODE.
  - DECODE (one cycle):
    - NOP: pc <= pc+1 -> RETIRE.
    - JMP: pc <= target -> RETIRE.
    - HALT -> HALT.
    - Illegal -> ERR.
    - ALU op: parameter1 <= p1, parameter2 <= p2, alu_sel <= opcode[2:0] -> DISPATCH.
  - DISPATCH: donefetch=1 for exactly one cycle, start=0; done ignored -> EXEC.
  - EXEC:
    - start=1 every cycle; counter increments.
    - done=1 sampled -> start drops the next cycle; pc <= pc+1 -> RETIRE.
    - Counter reaches TIMEOUT without done -> ERR.
  - RETIRE: one cycle. run=1 -> FETCH; run=0 -> IDLE.
  - HALT: halted=1, all strobes 0, held until reset.
  - ERR: err=1, start=0, donefetch=0, held until reset.
- parameter1, parameter2 and alu_sel stay stable from DISPATCH through the end of EXEC. They keep their last value afterwards and are reloaded only at the next ALU DECODE.
- Only one strobe class (mem_rd, donefetch, start) is active in any cycle.
- Timing:
  - Fetch-to-dispatch latency = 3 cycles (FETCH, LATCH, DECODE).
  - NOP/JMP take 4 cycles per instruction.
  - Counter clears on entering EXEC.
- Boundary cases:
  - pc wraps modulo 2^PC_W (0xFF+1 -> 0x00 with PC_W=8).
  - JMP to its own address loops indefinitely; this is legal.
  - run drops mid-instruction: the instruction completes, then the sequencer stops in IDLE at RETIRE.
  - done high during DISPATCH, or already high on EXEC entry from a stale value: only done sampled in EXEC counts, and not in the first EXEC cycle.
  - done arriving in the same cycle the counter hits TIMEOUT: done wins and the instruction retires.
  - Reset asserted mid-EXEC: start and donefetch go to 0 immediately (asynchronously).

Test Plan:
- ALU dispatch: mem[0]=0x1041 (op1, p1=1, p2=1); stub asserts done on the 7th start cycle -> donefetch one pulse, start high 7 cycles, parameter1=1, parameter2=1, alu_sel=1, pc 0->1.
- NOP/JMP: mem[0]=0x0000, mem[1]=0x8005 -> pc sequence 0,1,5; no donefetch or start asserted.
- HALT: mem[0]=0xF000 -> halted=1 from the cycle after DECODE; no further mem_rd over 20 cycles.
- Illegal op and bad register: mem[0]=0x9000 -> err=1. Separately, after reset, mem[0]=0x1140 (p1=5) -> err=1, no donefetch.
- Timeout: ALU op with done stuck 0 -> start high exactly 16 cycles, then err=1, start=0. Repeat with done arriving on the 16th cycle -> retires, err=0.
- Wrap and reset: PC_W=8, JMP to 0xFF holding NOP -> next fetch at 0x00. Assert rst low mid-EXEC -> all outputs 0 without waiting for a clock edge; pc=0.

Source files
------------

// File: rtl/instr_dispatch_seq.sv
// Instruction fetch/decode sequencer: fetches 16-bit words, executes NOP/JMP/HALT
// locally and hands ALU operations to the ALU sequencer through donefetch/start.
module instr_dispatch_seq #(
    parameter int          PC_W     = 8,
    parameter int          TIMEOUT  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            mem_rd,
    output logic [PC_W-1:0] mem_addr,
    input  logic [15:0]     mem_data,
    input  logic            done,
    output logic            donefetch,
    output logic            start,
    output logic [5:0]      parameter1,
    output logic [5:0]      parameter2,
    output logic [2:0]      alu_sel,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [5:0]       MAX_REG  = 6'd4;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_LATCH, S_DECODE, S_DISPATCH,
        S_EXEC, S_RETIRE, S_HALT, S_ERR
    } state_e;

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic [5:0]       p1_q, p1_d, p2_q, p2_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0] opcode;
    logic [5:0] ir_p1, ir_p2;

    assign opcode = ir_q[15:12];
    assign ir_p1  = ir_q[11:6];
    assign ir_p2  = ir_q[5:0];

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        alu_sel_d = alu_sel_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE:   if (run) state_d = S_FETCH;
            S_FETCH:  state_d = S_LATCH;
            S_LATCH: begin
                ir_d    = mem_data;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    4'h0: begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_RETIRE;
                    end
                    4'h8: begin
                        pc_d    = ir_q[PC_W-1:0];
                        state_d = S_RETIRE;
                    end
                    4'hF: state_d = S_HALT;
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                        if (ir_p1 > MAX_REG || ir_p2 > MAX_REG) begin
                            state_d = S_ERR;
                        end else begin
                            p1_d      = ir_p1;
                            p2_d      = ir_p2;
                            alu_sel_d = opcode[2:0];
                            state_d   = S_DISPATCH;
                        end
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_DISPATCH: begin
                cnt_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // A done seen in the first EXEC cycle may be stale from the previous op.
                if (done && cnt_q != '0) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = S_RETIRE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RETIRE: state_d = run ? S_FETCH : S_IDLE;
            S_HALT:   state_d = S_HALT;
            S_ERR:    state_d = S_ERR;
            default:  state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_W'(RESET_PC);
            ir_q      <= '0;
            p1_q      <= '0;
            p2_q      <= '0;
            alu_sel_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            alu_sel_q <= alu_sel_d;
            cnt_q     <= cnt_d;
        end
    end

    // Strobes decode straight from the state flop, so reset clears them without a clock.
    assign mem_rd     = (state_q == S_FETCH);
    assign donefetch  = (state_q == S_DISPATCH);
    assign start      = (state_q == S_EXEC);
    assign halted     = (state_q == S_HALT);
    assign err        = (state_q == S_ERR);
    assign mem_addr   = pc_q;
    assign pc         = pc_q;
    assign parameter1 = p1_q;
    assign parameter2 = p2_q;
    assign alu_sel    = alu_sel_q;

endmodule

// File: tb/tb_instr_dispatch_seq.sv
// Directed bench for instr_dispatch_seq: program memory model, ALU done stub,
// strobe monitor and hand-computed expectations.
module tb_instr_dispatch_seq;

    localparam int PC_W = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic            mem_rd;
    logic [PC_W-1:0] mem_addr;
    logic [15:0]     mem_data;
    logic            done;
    logic            donefetch;
    logic            start;
    logic [5:0]      parameter1;
    logic [5:0]      parameter2;
    logic [2:0]      alu_sel;
    logic [PC_W-1:0] pc;
    logic            halted;
    logic            err;

    logic [15:0]     mem [256];
    logic [PC_W-1:0] fetch_q [$];
    int              rd_cnt, df_cnt, st_cnt, strobe_viol;
    int              done_at;
    int              vectors, miscompares;

    instr_dispatch_seq #(.PC_W(PC_W), .TIMEOUT(16), .RESET_PC(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .done       (done),
        .donefetch  (donefetch),
        .start      (start),
        .parameter1 (parameter1),
        .parameter2 (parameter2),
        .alu_sel    (alu_sel),
        .pc         (pc),
        .halted     (halted),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Program memory: word valid the cycle after mem_rd.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= mem[mem_addr];
    end

    // Monitor and ALU stub: done is raised during the done_at-th start cycle.
    always @(negedge clk) begin
        if (!rst) begin
            rd_cnt      = 0;
            df_cnt      = 0;
            st_cnt      = 0;
            strobe_viol = 0;
            fetch_q.delete();
            done        = 1'b0;
        end else begin
            if (mem_rd) begin
                rd_cnt++;
                fetch_q.push_back(mem_addr);
            end
            if (donefetch) df_cnt++;
            if (start) st_cnt++;
            if (int'(mem_rd) + int'(donefetch) + int'(start) > 1) strobe_viol++;
            done = (done_at != 0) && start && (st_cnt == done_at);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic load_default();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        run = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // which: 0 = halted, 1 = err, 2 = start. Returns cycles taken; expiry is a miscompare.
    task automatic wait_for(input int which, input int bound, input string tag, output int n);
        bit hit;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < bound) begin
            step();
            n++;
            case (which)
                0:       hit = halted;
                1:       hit = err;
                default: hit = start;
            endcase
        end
        check({tag, "_reached"}, 32'(hit), 32'd1);
    endtask

    initial begin
        int n;
        int rd_snap;
        vectors     = 0;
        miscompares = 0;
        done_at     = 0;
        rst         = 1'b0;
        run         = 1'b0;
        load_default();
        #1;
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_donefetch", 32'(donefetch), 32'd0);
        check("rst_flags", {30'd0, halted, err}, 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_params", {17'd0, parameter1, parameter2, alu_sel}, 32'd0);

        // Idle with run low: nothing fetched.
        do_reset();
        repeat (5) step();
        check("idle_no_fetch", 32'(rd_cnt), 32'd0);

        // ALU dispatch, run dropped mid-instruction.
        load_default();
        mem[0]  = 16'h1041;
        done_at = 7;
        do_reset();
        run = 1'b1;
        wait_for(2, 20, "alu_start", n);
        check("alu_dispatch_latency", 32'(n), 32'd5);
        check("alu_p1", 32'(parameter1), 32'd1);
        check("alu_p2", 32'(parameter2), 32'd1);
        check("alu_sel", 32'(alu_sel), 32'd1);
        run = 1'b0;
        repeat (30) step();
        check("alu_donefetch_cnt", 32'(df_cnt), 32'd1);
        check("alu_start_cnt", 32'(st_cnt), 32'd7);
        check("alu_pc", 32'(pc), 32'd1);
        check("alu_stopped_idle", 32'(rd_cnt), 32'd1);
        check("alu_not_halted", 32'(halted), 32'd0);
        check("alu_p1_kept", 32'(parameter1), 32'd1);

        // NOP then JMP 5 (mem[5] is HALT).
        load_default();
        mem[0]  = 16'h0000;
        mem[1]  = 16'h8005;
        done_at = 0;
        do_reset();
        run = 1'b1;
        wait_for(0, 40, "nopjmp_halt", n);
        check("nopjmp_cycles", 32'(n), 32'd12);
        check("nopjmp_fetches", 32'(fetch_q.size()), 32'd3);
        check("nopjmp_f0", 32'(fetch_q[0]), 32'h00);
        check("nopjmp_f1", 32'(fetch_q[1]), 32'h01);
        check("nopjmp_f2", 32'(fetch_q[2]), 32'h05);
        check("nopjmp_no_alu", 32'(df_cnt + st_cnt), 32'd0);

        // HALT: flag appears the cycle after DECODE, then no more fetches.
        load_default();
        do_reset();
        run = 1'b1;
        step(); step(); step();
        check("halt_decode_cycle", 32'(halted), 32'd0);
        step();
        check("halt_set", 32'(halted), 32'd1);
        rd_snap = rd_cnt;
        repeat (20) step();
        check("halt_no_fetch", 32'(rd_cnt - rd_snap), 32'd0);
        check("halt_fetch_total", 32'(rd_cnt), 32'd1);
        check("halt_held", 32'(halted), 32'd1);

        // Illegal opcode, then bad register select.
        load_default();
        mem[0] = 16'h9000;
        do_reset();
        run = 1'b1;
        wait_for(1, 20, "illegal_op", n);
        check("illegal_op_halted", 32'(halted), 32'd0);
        load_default();
        mem[0] = 16'h1140;
        do_reset();
        run = 1'b1;
        wait_for(1, 20, "bad_reg", n);
        check("bad_reg_no_dispatch", 32'(df_cnt), 32'd0);
        repeat (3) step();
        check("bad_reg_err_held", 32'(err), 32'd1);

        // Timeout with done stuck low.
        load_default();
        mem[0]  = 16'h2083;
        done_at = 0;
        do_reset();
        run = 1'b1;
        wait_for(1, 60, "timeout_err", n);
        check("timeout_start_cnt", 32'(st_cnt), 32'd16);
        check("timeout_start_low", 32'(start), 32'd0);
        check("timeout_params", {23'd0, parameter1, alu_sel}, {23'd0, 6'd2, 3'd2});
        check("timeout_p2", 32'(parameter2), 32'd3);

        // Done on the 16th start cycle wins over the timeout.
        done_at = 16;
        do_reset();
        run = 1'b1;
        wait_for(0, 60, "late_done_retire", n);
        check("late_done_err", 32'(err), 32'd0);
        check("late_done_start_cnt", 32'(st_cnt), 32'd16);
        check("late_done_pc", 32'(pc), 32'd1);

        // PC wrap: JMP 0xFF, NOP at 0xFF, next fetch at 0x00.
        load_default();
        mem[0]   = 16'h80FF;
        mem[255] = 16'h0000;
        done_at  = 0;
        do_reset();
        run = 1'b1;
        repeat (20) step();
        check("wrap_fetch_cnt_ok", 32'(fetch_q.size() >= 3), 32'd1);
        check("wrap_f1", 32'(fetch_q[1]), 32'hFF);
        check("wrap_f2", 32'(fetch_q[2]), 32'h00);
        check("wrap_no_err", 32'(err | halted), 32'd0);

        // Asynchronous reset mid-EXEC.
        load_default();
        mem[0]    = 16'h8010;
        mem[16]   = 16'h1041;
        done_at   = 0;
        do_reset();
        run = 1'b1;
        wait_for(2, 30, "arst_exec", n);
        step();
        check("arst_pre_start", 32'(start), 32'd1);
        check("arst_pre_pc", 32'(pc), 32'h10);
        #2;
        rst = 1'b0;
        #1;
        check("arst_start", 32'(start), 32'd0);
        check("arst_donefetch", 32'(donefetch), 32'd0);
        check("arst_pc", 32'(pc), 32'd0);
        check("arst_params", {17'd0, parameter1, parameter2, alu_sel}, 32'd0);
        check("arst_flags", {29'd0, mem_rd, halted, err}, 32'd0);

        check("strobe_exclusive", 32'(strobe_viol), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
